// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor and ALU control:
// FSM state encoding and the default CPU datapath width.
package serial_subtractor_pkg;

  localparam int CPU_DATA_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } sub_state_t;

endpackage : serial_subtractor_pkg

// File: rtl/serial_subtractor_if.sv
// Request/result bundle between the ALU (master) and the serial subtractor (slave).
// Optional zero/overflow status lines exist only when SUB_STATUS_FLAGS_EN is defined.
interface serial_subtractor_if
  import serial_subtractor_pkg::*;
#(
  parameter int W = CPU_DATA_W
);

  logic         start_i;
  logic [W-1:0] a_i;
  logic [W-1:0] b_i;
  logic         borrow_i;
  logic         ready_o;
  logic         done_o;
  logic [W-1:0] diff_o;
  logic         borrow_o;
`ifdef SUB_STATUS_FLAGS_EN
  logic         zero_o;
  logic         ovf_o;
`endif

  modport master (
    output start_i, a_i, b_i, borrow_i,
`ifdef SUB_STATUS_FLAGS_EN
    input  zero_o, ovf_o,
`endif
    input  ready_o, done_o, diff_o, borrow_o
  );

  modport slave (
    input  start_i, a_i, b_i, borrow_i,
`ifdef SUB_STATUS_FLAGS_EN
    output zero_o, ovf_o,
`endif
    output ready_o, done_o, diff_o, borrow_o
  );

endinterface : serial_subtractor_if

// File: rtl/serial_subtractor_full_subtractor.sv
// Single-bit full subtractor cell: diff = a ^ b ^ bin, borrow out when a < b + bin.
module full_subtractor (
  input  logic a_i,
  input  logic b_i,
  input  logic borrow_i,
  output logic diff_o,
  output logic borrow_o
);

  logic w_axb;

  assign w_axb    = a_i ^ b_i;
  assign diff_o   = w_axb ^ borrow_i;
  assign borrow_o = (~a_i & b_i) | (~w_axb & borrow_i);

endmodule : full_subtractor

// File: rtl/serial_subtractor.sv
// Bit-serial a - b - borrow_in, LSB first, one bit per clock through one full-subtractor cell.
// Optional zero/overflow status flags are built when SUB_STATUS_FLAGS_EN is defined.
//
//   state | meaning
//   IDLE  | ready for a request, outputs hold the last result
//   SHIFT | one operand bit per cycle, SUB_BIT_NUMB cycles
//   DONE  | result published, done pulse for this single cycle
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int SUB_BIT_NUMB = CPU_DATA_W
) (
  input  logic                clk_i,
  input  logic                rst_i,
  serial_subtractor_if.slave  sub_if
);

  localparam int CNT_W = $clog2(SUB_BIT_NUMB);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SUB_BIT_NUMB - 1);

  sub_state_t              r_state;
  logic [CNT_W-1:0]        r_cnt;
  logic [SUB_BIT_NUMB-1:0] r_a;
  logic [SUB_BIT_NUMB-1:0] r_b;
  logic [SUB_BIT_NUMB-2:0] r_res;
  logic                    r_br;
  logic                    r_ready;
  logic                    r_done;
  logic [SUB_BIT_NUMB-1:0] r_diff;
  logic                    r_borrow;
`ifdef SUB_STATUS_FLAGS_EN
  logic                    r_a_msb;
  logic                    r_b_msb;
  logic                    r_zero;
  logic                    r_ovf;
`endif

  logic                    w_d;
  logic                    w_br_nxt;
  logic [SUB_BIT_NUMB-1:0] w_res_all;

  full_subtractor u_fs (
    .a_i      (r_a[0]),
    .b_i      (r_b[0]),
    .borrow_i (r_br),
    .diff_o   (w_d),
    .borrow_o (w_br_nxt)
  );

  // New bit enters at the MSB side; after the last bit this is the full result.
  assign w_res_all = {w_d, r_res};

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_res    <= '0;
      r_br     <= 1'b0;
      r_ready  <= 1'b1;
      r_done   <= 1'b0;
      r_diff   <= '0;
      r_borrow <= 1'b0;
`ifdef SUB_STATUS_FLAGS_EN
      r_a_msb  <= 1'b0;
      r_b_msb  <= 1'b0;
      r_zero   <= 1'b0;
      r_ovf    <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (sub_if.start_i && r_ready) begin
            r_a     <= sub_if.a_i;
            r_b     <= sub_if.b_i;
            r_br    <= sub_if.borrow_i;
            r_cnt   <= '0;
            r_ready <= 1'b0;
            r_state <= SHIFT;
`ifdef SUB_STATUS_FLAGS_EN
            r_a_msb <= sub_if.a_i[SUB_BIT_NUMB-1];
            r_b_msb <= sub_if.b_i[SUB_BIT_NUMB-1];
`endif
          end
        end
        SHIFT: begin
          r_a   <= r_a >> 1;
          r_b   <= r_b >> 1;
          r_br  <= w_br_nxt;
          r_res <= w_res_all[SUB_BIT_NUMB-1:1];
          r_cnt <= r_cnt + CNT_W'(1);
          if (r_cnt == CNT_LAST) begin
            r_state  <= DONE;
            r_done   <= 1'b1;
            r_diff   <= w_res_all;
            r_borrow <= w_br_nxt;
`ifdef SUB_STATUS_FLAGS_EN
            r_zero   <= (w_res_all == '0);
            // Overflow only possible when operand signs differ.
            r_ovf    <= (r_a_msb != r_b_msb) && (w_d != r_a_msb);
`endif
          end
        end
        DONE: begin
          r_done  <= 1'b0;
          r_ready <= 1'b1;
          r_state <= IDLE;
        end
        default: begin
          r_done  <= 1'b0;
          r_ready <= 1'b1;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign sub_if.ready_o  = r_ready;
  assign sub_if.done_o   = r_done;
  assign sub_if.diff_o   = r_diff;
  assign sub_if.borrow_o = r_borrow;
`ifdef SUB_STATUS_FLAGS_EN
  assign sub_if.zero_o   = r_zero;
  assign sub_if.ovf_o    = r_ovf;
`endif

endmodule : serial_subtractor

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: arithmetic reference model plus directed vectors.
module tb_serial_subtractor;

  localparam int N = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  bit   chk_en = 1'b0;

  serial_subtractor_if #(.W(N)) sub_if ();

  serial_subtractor #(.SUB_BIT_NUMB(N)) dut (
    .clk_i  (clk),
    .rst_i  (rst),
    .sub_if (sub_if.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: operation takes N+1 cycles from acceptance to the done cycle,
  // and one more cycle before a new request can be taken.
  int         m_left   = 0;
  logic       m_ready  = 1'b1;
  logic       m_done   = 1'b0;
  logic [3:0] m_diff   = '0;
  logic       m_borrow = 1'b0;
  logic       m_zero   = 1'b0;
  logic       m_ovf    = 1'b0;
  logic [3:0] p_diff;
  logic       p_borrow, p_zero, p_ovf;

  always @(posedge clk) begin
    if (rst) begin
      m_left = 0; m_ready = 1'b1; m_done = 1'b0;
      m_diff = '0; m_borrow = 1'b0; m_zero = 1'b0; m_ovf = 1'b0;
    end else if (m_left == 0) begin
      if (sub_if.start_i) begin
        int ua, ub, sa, sb, sr;
        ua = int'(sub_if.a_i);
        ub = int'(sub_if.b_i) + int'(sub_if.borrow_i);
        sa = int'($signed(sub_if.a_i));
        sb = int'($signed(sub_if.b_i));
        sr = sa - sb - int'(sub_if.borrow_i);
        p_diff   = 4'((ua - ub) & 15);
        p_borrow = (ua < ub);
        p_zero   = (p_diff == 4'd0);
        p_ovf    = (sr < -8) || (sr > 7);
        m_left   = N + 1;
        m_ready  = 1'b0;
      end
    end else begin
      m_left = m_left - 1;
      if (m_left == 1) begin
        m_done = 1'b1; m_diff = p_diff; m_borrow = p_borrow;
        m_zero = p_zero; m_ovf = p_ovf;
      end else if (m_left == 0) begin
        m_done = 1'b0; m_ready = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("cyc_ready",  32'(sub_if.ready_o),  32'(m_ready));
      chk("cyc_done",   32'(sub_if.done_o),   32'(m_done));
      chk("cyc_diff",   32'(sub_if.diff_o),   32'(m_diff));
      chk("cyc_borrow", 32'(sub_if.borrow_o), 32'(m_borrow));
`ifdef SUB_STATUS_FLAGS_EN
      chk("cyc_zero",   32'(sub_if.zero_o),   32'(m_zero));
      chk("cyc_ovf",    32'(sub_if.ovf_o),    32'(m_ovf));
`endif
    end
  end

  task automatic wait_done(input string nm, output int cyc);
    cyc = 1;
    while (!sub_if.done_o && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    chk({nm, "_latency"}, 32'(cyc), 32'd5);
  endtask

  task automatic do_op(input string nm, input logic [3:0] a, input logic [3:0] b, input logic bi,
                       input logic [3:0] ed, input logic eb, input logic ez, input logic eo);
    int cyc;
    @(negedge clk);
    sub_if.start_i = 1'b1; sub_if.a_i = a; sub_if.b_i = b; sub_if.borrow_i = bi;
    @(negedge clk);
    sub_if.start_i = 1'b0;
    wait_done(nm, cyc);
    chk({nm, "_diff"},   32'(sub_if.diff_o),   32'(ed));
    chk({nm, "_borrow"}, 32'(sub_if.borrow_o), 32'(eb));
    chk({nm, "_model"},  32'({m_borrow, m_diff}), 32'({eb, ed}));
`ifdef SUB_STATUS_FLAGS_EN
    chk({nm, "_zero"},   32'(sub_if.zero_o),   32'(ez));
    chk({nm, "_ovf"},    32'(sub_if.ovf_o),    32'(eo));
`else
    if (ez && eo) $display("note: %s expects zero and ovf together", nm);
`endif
  endtask

  initial begin
    int cyc, pulses;
    sub_if.start_i = 1'b0; sub_if.a_i = '0; sub_if.b_i = '0; sub_if.borrow_i = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk_en = 1'b1;
    chk("rst_ready",  32'(sub_if.ready_o),  32'd1);
    chk("rst_done",   32'(sub_if.done_o),   32'd0);
    chk("rst_diff",   32'(sub_if.diff_o),   32'd0);
    chk("rst_borrow", 32'(sub_if.borrow_o), 32'd0);

    do_op("v1", 4'b0011, 4'b0001, 1'b0, 4'b0010, 1'b0, 1'b0, 1'b0);
    do_op("v2", 4'b0001, 4'b0010, 1'b0, 4'b1111, 1'b1, 1'b0, 1'b0);
    do_op("v3", 4'b0000, 4'b0000, 1'b1, 4'b1111, 1'b1, 1'b0, 1'b0);
    do_op("v4", 4'b1111, 4'b1111, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b0);
    do_op("v5", 4'b0111, 4'b1111, 1'b0, 4'b1000, 1'b1, 1'b0, 1'b1);
    do_op("v6", 4'b1000, 4'b0000, 1'b1, 4'b0111, 1'b0, 1'b0, 1'b1);

    // start held high with changing operands while busy
    @(negedge clk);
    sub_if.start_i = 1'b1; sub_if.a_i = 4'b0011; sub_if.b_i = 4'b0001; sub_if.borrow_i = 1'b0;
    @(negedge clk);
    sub_if.a_i = 4'b1111; sub_if.b_i = 4'b0000; sub_if.borrow_i = 1'b1;
    cyc = 1;
    while (!sub_if.done_o && cyc < 20) begin
      @(negedge clk);
      sub_if.a_i = sub_if.a_i - 4'd1;
      cyc++;
    end
    chk("hold_latency", 32'(cyc), 32'd5);
    chk("hold_diff",    32'(sub_if.diff_o), 32'b0010);
    sub_if.start_i = 1'b0;
    pulses = 1;
    repeat (6) begin
      @(negedge clk);
      if (sub_if.done_o) pulses++;
    end
    chk("hold_pulses",  32'(pulses), 32'd1);
    chk("hold_keep",    32'(sub_if.diff_o), 32'b0010);

    // reset two cycles into SHIFT aborts the operation
    do_op("pre_rst", 4'b0001, 4'b0010, 1'b0, 4'b1111, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    sub_if.start_i = 1'b1; sub_if.a_i = 4'b0101; sub_if.b_i = 4'b0010; sub_if.borrow_i = 1'b0;
    @(negedge clk);
    sub_if.start_i = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_ready",  32'(sub_if.ready_o),  32'd1);
    chk("abort_diff",   32'(sub_if.diff_o),   32'd0);
    chk("abort_borrow", 32'(sub_if.borrow_o), 32'd0);
    pulses = 0;
    repeat (8) begin
      @(negedge clk);
      if (sub_if.done_o) pulses++;
    end
    chk("abort_nodone", 32'(pulses), 32'd0);
    do_op("post_rst", 4'b0101, 4'b0010, 1'b0, 4'b0011, 1'b0, 1'b0, 1'b0);

    // back-to-back: request on the first IDLE cycle after DONE
    do_op("b2b_1", 4'b1010, 4'b0011, 1'b0, 4'b0111, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    sub_if.start_i = 1'b1; sub_if.a_i = 4'b0010; sub_if.b_i = 4'b0101; sub_if.borrow_i = 1'b1;
    @(negedge clk);
    sub_if.start_i = 1'b0;
    chk("b2b_busy", 32'(sub_if.ready_o), 32'd0);
    chk("b2b_hold", 32'(sub_if.diff_o),  32'b0111);
    wait_done("b2b_2", cyc);
    chk("b2b_2_diff",   32'(sub_if.diff_o),   32'b1100);
    chk("b2b_2_borrow", 32'(sub_if.borrow_o), 32'd1);

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_serial_subtractor
